// File: rtl/ctrl_pipe.sv
// Control-word pipeline between decode and writeback: per-stage stall/flush, back-propagated
// hold, bubble insertion, flush-immune bits, occupancy count and a saturating stall counter.
module ctrl_pipe #(
  parameter int unsigned W                = 24,
  parameter int unsigned STAGES           = 3,
  parameter logic [W-1:0] NOFLUSH_MASK    = '0,
  parameter int unsigned CW               = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 in_ctrl,
  input  logic                         in_valid,
  input  logic [STAGES-1:0]            stall_i,
  input  logic [STAGES-1:0]            flush_i,
  output logic [STAGES*W-1:0]          ctrl_o,
  output logic [STAGES-1:0]            valid_o,
  output logic                         stall_o,
  output logic [$clog2(STAGES+1)-1:0]  count_o,
  output logic [CW-1:0]                stall_cycles_o
);

  localparam int unsigned CntW = $clog2(STAGES + 1);

  logic [STAGES-1:0]         hold;
  logic [STAGES-1:0]         up_stall;
  logic [STAGES-1:0]         up_valid;
  logic [STAGES-1:0][W-1:0]  up_ctrl;

  logic [STAGES-1:0][W-1:0]  ctrl_q, ctrl_d;
  logic [STAGES-1:0]         valid_q, valid_d;
  logic [CW-1:0]             stall_cyc_q, stall_cyc_d;
  logic [CntW-1:0]           count;

  // A stage holds whenever it or anything downstream of it is stalled.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_i[STAGES-1];
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      hold[i] = stall_i[i] | hold[i+1];
    end
  end

  assign stall_o = hold[0];

  always_comb begin
    up_ctrl     = '0;
    up_valid    = '0;
    up_stall    = '0;
    up_ctrl[0]  = in_ctrl;
    up_valid[0] = in_valid;
    for (int i = 1; i < int'(STAGES); i++) begin
      up_ctrl[i]  = ctrl_q[i-1];
      up_valid[i] = valid_q[i-1];
      up_stall[i] = stall_i[i-1];
    end
  end

  // Flush is applied on top of the hold/bubble/load result so immune bits keep flowing.
  always_comb begin
    ctrl_d  = '0;
    valid_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (hold[i]) begin
        ctrl_d[i]  = ctrl_q[i];
        valid_d[i] = valid_q[i];
      end else if (up_stall[i]) begin
        ctrl_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else begin
        ctrl_d[i]  = up_ctrl[i];
        valid_d[i] = up_valid[i];
      end
      if (flush_i[i]) begin
        ctrl_d[i]  = ctrl_d[i] & NOFLUSH_MASK;
        valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cyc_d = '0;
    if (stall_o) begin
      stall_cyc_d = (stall_cyc_q == {CW{1'b1}}) ? stall_cyc_q : stall_cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      valid_q     <= '0;
      stall_cyc_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      count = count + CntW'(valid_q[i]);
    end
  end

  assign ctrl_o         = ctrl_q;
  assign valid_o        = valid_q;
  assign count_o        = count;
  assign stall_cycles_o = stall_cyc_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus random traffic against a stage-array model;
// a second instance with a 2-bit stall counter covers saturation.
module tb_ctrl_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;
  localparam logic [7:0]  Mask = 8'h80;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     in_ctrl;
  logic           in_valid;
  logic [2:0]     stall_i;
  logic [2:0]     flush_i;

  logic [23:0]    ctrl_a, ctrl_b;
  logic [2:0]     valid_a, valid_b;
  logic           stall_a, stall_b;
  logic [1:0]     count_a, count_b;
  logic [7:0]     cyc_a;
  logic [1:0]     cyc_b;

  int vecs = 0;
  int errs = 0;

  // Reference state: one entry per stage, plus the two stall counters.
  int mc [3];
  int mv [3];
  int mcnt_a, mcnt_b;

  always #5 clk = ~clk;

  ctrl_pipe #(.W(W), .STAGES(S), .NOFLUSH_MASK(Mask), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .stall_i(stall_i),
    .flush_i(flush_i), .ctrl_o(ctrl_a), .valid_o(valid_a), .stall_o(stall_a),
    .count_o(count_a), .stall_cycles_o(cyc_a)
  );

  ctrl_pipe #(.W(W), .STAGES(S), .NOFLUSH_MASK(Mask), .CW(2)) dut_b (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .stall_i(stall_i),
    .flush_i(flush_i), .ctrl_o(ctrl_b), .valid_o(valid_b), .stall_o(stall_b),
    .count_o(count_b), .stall_cycles_o(cyc_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0;
      mv[i] = 0;
    end
    mcnt_a = 0;
    mcnt_b = 0;
  endtask

  task automatic drive(input logic [7:0] c, input logic v, input logic [2:0] st,
                       input logic [2:0] fl);
    in_ctrl  = c;
    in_valid = v;
    stall_i  = st;
    flush_i  = fl;
  endtask

  task automatic check_all(input string tag);
    logic [23:0] ec;
    logic [2:0]  ev;
    ec = {mc[2][7:0], mc[1][7:0], mc[0][7:0]};
    ev = {mv[2][0], mv[1][0], mv[0][0]};
    chk({tag, ".ctrl"}, 64'(ctrl_a), 64'(ec));
    chk({tag, ".valid"}, 64'(valid_a), 64'(ev));
    chk({tag, ".count"}, 64'(count_a), 64'(mv[0] + mv[1] + mv[2]));
    chk({tag, ".cyc_a"}, 64'(cyc_a), 64'(mcnt_a));
    chk({tag, ".cyc_b"}, 64'(cyc_b), 64'(mcnt_b));
    chk({tag, ".ctrl_b"}, 64'(ctrl_b), 64'(ec));
  endtask

  // One clock: check the combinational stall, advance the model by the stage rules, compare.
  task automatic tick(input string tag);
    logic [2:0] held;
    int nc [3];
    int nv [3];
    for (int i = 0; i < 3; i++) held[i] = |(stall_i >> i);
    chk({tag, ".stall_o"}, 64'(stall_a), 64'(held[0]));
    chk({tag, ".stall_o_b"}, 64'(stall_b), 64'(held[0]));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (held[i]) begin
        nc[i] = mc[i];
        nv[i] = mv[i];
      end else if (i > 0 && stall_i[i-1]) begin
        nc[i] = 0;
        nv[i] = 0;
      end else if (i == 0) begin
        nc[i] = int'(in_ctrl);
        nv[i] = int'(in_valid);
      end else begin
        nc[i] = mc[i-1];
        nv[i] = mv[i-1];
      end
      if (flush_i[i]) begin
        nc[i] = nc[i] & int'(Mask);
        nv[i] = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      mc[i] = nc[i];
      mv[i] = nv[i];
    end
    mcnt_a = held[0] ? ((mcnt_a < 255) ? mcnt_a + 1 : 255) : 0;
    mcnt_b = held[0] ? ((mcnt_b < 3) ? mcnt_b + 1 : 3) : 0;
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 1'b0, 3'b000, 3'b000);
    model_reset();
    #3;
    chk("reset.ctrl", 64'(ctrl_a), 64'(0));
    chk("reset.valid", 64'(valid_a), 64'(0));
    chk("reset.count", 64'(count_a), 64'(0));
    chk("reset.cyc", 64'(cyc_a), 64'(0));
    stall_i = 3'b100;
    #1;
    chk("reset.stall_follows", 64'(stall_a), 64'(1));
    stall_i = 3'b000;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stream three words.
    drive(8'h11, 1'b1, 3'b000, 3'b000); tick("stream1");
    drive(8'h22, 1'b1, 3'b000, 3'b000); tick("stream2");
    drive(8'h33, 1'b1, 3'b000, 3'b000); tick("stream3");
    chk("stream.ctrl_const", 64'(ctrl_a), 64'(24'h112233));
    chk("stream.count_const", 64'(count_a), 64'(3));

    // Mid-stage stall for two cycles, then release.
    drive(8'h44, 1'b1, 3'b010, 3'b000); tick("midstall1");
    chk("midstall1.cyc_const", 64'(cyc_a), 64'(1));
    chk("midstall1.bubble", 64'({ctrl_a[23:16], valid_a[2]}), 64'(0));
    chk("midstall1.hold", 64'(ctrl_a[15:0]), 64'(16'h2233));
    tick("midstall2");
    chk("midstall2.cyc_const", 64'(cyc_a), 64'(2));
    chk("midstall2.bubble", 64'({ctrl_a[23:16], valid_a[2]}), 64'(0));
    drive(8'h44, 1'b1, 3'b000, 3'b000); tick("midstall_rel");
    chk("midstall_rel.cyc_const", 64'(cyc_a), 64'(0));

    // Flush of stage 0 keeps only the immune bit.
    drive(8'hFF, 1'b1, 3'b000, 3'b000); tick("preflush");
    drive(8'h85, 1'b1, 3'b000, 3'b001); tick("flushmask");
    chk("flushmask.s0", 64'({ctrl_a[7:0], valid_a[0]}), 64'({8'h80, 1'b0}));

    // Simultaneous stall and flush on stage 2 (holding 8'h44).
    chk("flushstall.pre", 64'(ctrl_a[23:16]), 64'(8'h44));
    drive(8'h5A, 1'b1, 3'b100, 3'b100); tick("flushstall");
    chk("flushstall.s2", 64'({ctrl_a[23:16], valid_a[2]}), 64'(0));
    chk("flushstall.s01", 64'(ctrl_a[15:0]), 64'(16'hFF80));

    // Saturation of the 2-bit counter.
    drive(8'h00, 1'b0, 3'b000, 3'b000); tick("sat_clear");
    drive(8'h66, 1'b1, 3'b100, 3'b000);
    for (int k = 0; k < 5; k++) begin
      tick("sat");
      chk("sat.cyc_b_const", 64'(cyc_b), 64'((k < 3) ? k + 1 : 3));
    end
    drive(8'h00, 1'b0, 3'b000, 3'b000); tick("sat_rel");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] st, fl;
      for (int b = 0; b < 3; b++) begin
        st[b] = ($urandom_range(0, 4) == 0);
        fl[b] = ($urandom_range(0, 7) == 0);
      end
      drive(8'($urandom), 1'($urandom), st, fl);
      tick("rand");
    end

    // Fill, then reset between edges.
    for (int n = 0; n < 3; n++) begin
      drive(8'($urandom_range(1, 255)), 1'b1, 3'b000, 3'b000);
      tick("refill");
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.ctrl", 64'(ctrl_a), 64'(0));
    chk("async_rst.valid", 64'(valid_a), 64'(0));
    chk("async_rst.count", 64'(count_a), 64'(0));
    rst = 1'b0;
    model_reset();
    drive(8'h77, 1'b1, 3'b000, 3'b000); tick("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline for the MIPS core, replacing the hand-built per-stage control registers between decode and writeback. It carries a W-bit decoded control word plus a valid bit through STAGES register stages (stage 0 = execute), with per-stage stall and flush. It also provides:
- back-propagated stall and automatic bubble insertion;
- a per-bit flush-immunity mask, generalising the unflushable HI/LO-enable path;
- a valid-stage occupancy count and a saturating stall-cycle counter for hazard debug.

## Interface
Parameters:
- W, 24, control word width per stage (≥1)
- STAGES, 3, number of register stages after decode (≥2)
- NOFLUSH_MASK, {W{1'b0}}, bit set = that control bit ignores flush and loads normally
- CW, 8, width of stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_ctrl  in  W  control word from decode
- in_valid  in  1  decode word is a real instruction
- stall_i  in  STAGES  per-stage local stall request, bit i = stage i
- flush_i  in  STAGES  per-stage flush request
- ctrl_o  out  STAGES*W  stage i word at bits [i*W +: W]
- valid_o  out  STAGES  stage i valid
- stall_o  out  1  decode must hold (equals hold[0])
- count_o  out  $clog2(STAGES+1)  number of set valid_o bits
- stall_cycles_o  out  CW  consecutive cycles stall_o has been high, saturating

## Operation
- Hold chain (combinational): hold[STAGES-1] = stall_i[STAGES-1]; hold[i] = stall_i[i] | hold[i+1]. Stalls therefore propagate upstream.
- Per stage i, next-state is evaluated in priority order:
  1. flush_i[i]: valid ← 0. Masked bits (NOFLUSH_MASK=1) take the value they would have taken without flush (per rules 2–4). Unmasked bits ← 0. Flush wins over hold.
  2. hold[i]: ctrl and valid unchanged.
  3. i>0 and stall_i[i-1] (upstream stalled, this stage free): bubble, ctrl ← 0, valid ← 0.
  4. Otherwise load upstream. Stage 0 loads in_ctrl/in_valid. Stage i>0 loads stage i-1 ctrl/valid.
- Stage 0 never bubbles. When stall_o=1, the decoder holds in_ctrl, and the block ignores in_ctrl that cycle.
- count_o = popcount(valid_o), combinational from registers only.
- stall_cycles_o: if stall_o, then +1, saturating at 2^CW−1; else ← 0. Registered.
- A flush on a held stage does not release upstream holds; the hold chain depends only on stall_i.

## Timing
- Reset (async assert, sync to clk on release): all ctrl_o = 0, valid_o = 0, stall_cycles_o = 0. Consequently count_o = 0. stall_o follows stall_i even during reset.
- Latency: in_ctrl appears on stage 0 one cycle after acceptance, and on stage k after k+1 cycles, absent stalls.
- stall_o is combinational from stall_i (no register). All other outputs change only at clk edges.
- A simultaneous stall_i[i] and flush_i[i] clears stage i that edge while upstream stages still hold.
- Reset mid-stream clears all stages immediately, with no partial words.
- Counter saturation: at 2^CW−1 with stall_o still high, the value stays at 2^CW−1.

## Test plan
Settings: W=8, STAGES=3, NOFLUSH_MASK=8'h80.
- Reset then stream: in_ctrl=8'h11,8'h22,8'h33 valid on three cycles. Required: after cycle 3, ctrl_o = {8'h11,8'h22,8'h33} (stage2..0) and count_o = 3.
- Mid-stage stall: pipe holds A,B,C (stage0..2). Assert stall_i=3'b010 for 2 cycles. Required:
  - stall_o = 1;
  - stage0 and stage1 hold;
  - stage2 gets a bubble (8'h00, valid 0) and keeps bubbling;
  - stall_cycles_o reads 1 then 2, and returns to 0 one edge after release.
- Flush with mask: stage0 = 8'hFF, flush_i=3'b001, in_ctrl=8'h85. Required: stage0 ctrl = 8'h80, valid 0.
- Flush vs stall: stall_i=3'b100 and flush_i=3'b100 with stage2 = 8'h44. Required: stage2 → 8'h00, valid 0; stages 0 and 1 hold; stall_o = 1.
- Saturation with CW=2: hold stall_i[2]=1 for 5 cycles. Required: stall_cycles_o sequence 1,2,3,3,3.
- Async reset mid-stream: pulse rst between edges with full pipe. Required: valid_o = 0 and ctrl_o = 0 immediately, without waiting for clk.
